// File: rtl/pc_ras_unit.sv
// Purpose: fetch program counter with a circular return-address stack (RAS).
// Latency: every redirect (flush, return, branch) reaches pc on the next rising edge.
// Backpressure: stall holds pc, RAS contents, count and ras_err; only rst or flush override it.
//
// Ports:
//   clk, rst        single clock; synchronous active-high reset
//   stall           hold all state (flush and rst still act)
//   flush_flag/addr trap redirect; also empties the RAS
//   branch_flag/addr taken branch; with call_flag it also pushes ret_addr
//   ret_flag        return: redirect to the RAS top and pop it
//   pc              registered fetch address
//   ras_empty/full  occupancy status, decoded from the entry count
//   ras_err         sticky overflow/underflow indication, cleared only by rst
module pc_ras_unit #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                STEP      = 1,
  parameter int                RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush_flag,
  input  logic [ADDR_W-1:0] flush_addr,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              call_flag,
  input  logic [ADDR_W-1:0] ret_addr,
  input  logic              ret_flag,
  output logic [ADDR_W-1:0] pc,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_err
);

  localparam int                PTR_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int                CNT_W  = PTR_W + 1;
  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);
  localparam logic [CNT_W-1:0]  DEPTH_V = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  // wr_ptr points at the slot the next push will write; the top is one below.
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  top_ptr;
  logic [CNT_W-1:0]  count;
  logic              err_q;

  logic              active;
  logic              do_pop;
  logic              do_underflow;
  logic              do_push;
  logic              do_overflow;

  assign pc        = pc_q;
  assign ras_err   = err_q;
  assign ras_empty = (count == '0);
  assign ras_full  = (count == DEPTH_V);

  assign pc_seq  = pc_q + STEP_V;
  assign top_ptr = wr_ptr - PTR_W'(1);

  // "active" means the RAS/pc may advance this cycle: not flushed, not stalled.
  assign active       = ~flush_flag & ~stall;
  assign do_pop       = active & ret_flag & ~ras_empty;
  assign do_underflow = active & ret_flag & ras_empty;
  // A return in the same cycle wins over a call, so no push happens then.
  assign do_push      = active & ~ret_flag & branch_flag & call_flag;
  assign do_overflow  = do_push & ras_full;

  always_comb begin
    pc_nxt = pc_seq;
    if (flush_flag) begin
      pc_nxt = flush_addr;
    end else if (stall) begin
      pc_nxt = pc_q;
    end else if (ret_flag) begin
      // An empty stack falls through to the sequential address.
      pc_nxt = ras_empty ? pc_seq : ras_mem[top_ptr];
    end else if (branch_flag) begin
      pc_nxt = branch_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_VEC;
      wr_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      pc_q <= pc_nxt;
      if (flush_flag) begin
        // The pointer may stay anywhere; with count at zero nothing is readable.
        count <= '0;
      end else if (do_pop) begin
        wr_ptr <= top_ptr;
        count  <= count - CNT_W'(1);
      end else if (do_push) begin
        // When full the write slot is the oldest entry, so it is overwritten
        // and the count saturates at the depth.
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (!ras_full) begin
          count <= count + CNT_W'(1);
        end
      end
      if (do_underflow || do_overflow) begin
        err_q <= 1'b1;
      end
    end
  end

  // Entry storage has no reset: contents are only visible through count.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      ras_mem[wr_ptr] <= ret_addr;
    end
  end

endmodule

// File: tb/tb_pc_ras_unit.sv
// Purpose: randomized plus directed stimulus against a queue-based reference model.
// Latency: one expected record per clock edge, compared one edge after issue.
// Backpressure: none; the DUT presents pc/status every cycle.
module tb_pc_ras_unit;

  localparam int          AW    = 16;
  localparam int          DEPTH = 4;
  localparam logic [15:0] RV    = 16'h0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          flush_flag = 1'b0;
  logic [AW-1:0] flush_addr = '0;
  logic          branch_flag = 1'b0;
  logic [AW-1:0] branch_addr = '0;
  logic          call_flag = 1'b0;
  logic [AW-1:0] ret_addr = '0;
  logic          ret_flag = 1'b0;
  logic [AW-1:0] pc;
  logic          ras_empty;
  logic          ras_full;
  logic          ras_err;

  pc_ras_unit #(.ADDR_W(AW), .RESET_VEC(RV), .STEP(1), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .flush_flag(flush_flag), .flush_addr(flush_addr),
    .branch_flag(branch_flag), .branch_addr(branch_addr),
    .call_flag(call_flag), .ret_addr(ret_addr), .ret_flag(ret_flag),
    .pc(pc), .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic          empty;
    logic          full;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: the stack is a plain queue, newest entry at the back.
  logic [AW-1:0] m_pc  = '0;
  logic [AW-1:0] m_ras[$];
  bit            m_err = 1'b0;

  task automatic model_step(input bit r, s, f, input logic [AW-1:0] fa,
                            input bit b, input logic [AW-1:0] ba,
                            input bit c, input logic [AW-1:0] ra, input bit rt);
    if (r) begin
      m_pc = RV; m_ras.delete(); m_err = 1'b0;
    end else if (f) begin
      m_pc = fa; m_ras.delete();
    end else if (s) begin
      // hold everything
    end else if (rt) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin m_pc = m_pc + 16'd1; m_err = 1'b1; end
    end else if (b) begin
      m_pc = ba;
      if (c) begin
        m_ras.push_back(ra);
        if (m_ras.size() > DEPTH) begin
          void'(m_ras.pop_front());
          m_err = 1'b1;
        end
      end
    end else begin
      m_pc = m_pc + 16'd1;
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected result.
  task automatic drive(input bit r, s, f, input logic [AW-1:0] fa,
                       input bit b, input logic [AW-1:0] ba,
                       input bit c, input logic [AW-1:0] ra, input bit rt);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; flush_flag = f; flush_addr = fa;
    branch_flag = b; branch_addr = ba; call_flag = c; ret_addr = ra; ret_flag = rt;
    model_step(r, s, f, fa, b, ba, c, ra, rt);
    e.pc    = m_pc;
    e.empty = (m_ras.size() == 0);
    e.full  = (m_ras.size() == DEPTH);
    e.err   = m_err;
    exp_q.push_back(e);
  endtask

  task automatic free();                 drive(0,0,0,0,0,0,0,0,0); endtask
  task automatic do_reset();             drive(1,0,0,0,0,0,0,0,0); endtask
  task automatic call(input logic [AW-1:0] ba, ra); drive(0,0,0,0,1,ba,1,ra,0); endtask
  task automatic ret();                  drive(0,0,0,0,0,0,0,0,1); endtask

  // Directed constant checks, sampled just after the edge the last drive targets.
  task automatic expect_now(input string name, input logic [AW-1:0] epc,
                            input logic eempty, input logic eerr);
    @(posedge clk);
    #2;
    n_chk++;
    if (pc === epc && ras_empty === eempty && ras_err === eerr) n_pass++;
    else $display("FAIL %s: pc=%h empty=%b err=%b, required pc=%h empty=%b err=%b",
                  name, pc, ras_empty, ras_err, epc, eempty, eerr);
  endtask

  // Monitor: one output record per edge, compared against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if (pc === e.pc && ras_empty === e.empty && ras_full === e.full && ras_err === e.err)
          n_pass++;
        else
          $display("FAIL scoreboard t=%0t: pc=%h empty=%b full=%b err=%b, required pc=%h empty=%b full=%b err=%b",
                   $time, pc, ras_empty, ras_full, ras_err, e.pc, e.empty, e.full, e.err);
      end
    end
  end

  initial begin
    int wait_cyc;
    // Reset and three free cycles: 0,1,2,3.
    do_reset(); do_reset();
    free(); free(); free();
    expect_now("seq_after_reset", 16'd3, 1'b1, 1'b0);

    // Stalled branch holds pc, then takes effect.
    do_reset(); free(); free();
    drive(0,1,0,0,1,16'd10,0,0,0);
    expect_now("stall_holds_branch", 16'd2, 1'b1, 1'b0);
    drive(0,0,0,0,1,16'd10,0,0,0);
    expect_now("branch_taken", 16'd10, 1'b1, 1'b0);
    free();
    expect_now("after_branch_seq", 16'd11, 1'b1, 1'b0);

    // Nested calls and returns are LIFO.
    call(16'h20, 16'h5);
    call(16'h40, 16'h21);
    ret();
    expect_now("ret_inner", 16'h21, 1'b0, 1'b0);
    ret();
    expect_now("ret_outer", 16'h5, 1'b1, 1'b0);

    // Overflow on the fifth push, then four good pops and an underflow.
    do_reset();
    for (int i = 1; i <= 4; i++) call(16'h80, 16'(i));
    call(16'h80, 16'd5);
    expect_now("overflow_err", 16'h80, 1'b0, 1'b1);
    for (int i = 5; i >= 2; i--) ret();
    expect_now("last_good_pop", 16'd2, 1'b1, 1'b1);
    ret();
    expect_now("underflow_seq", 16'd3, 1'b1, 1'b1);

    // Flush beats stall and empties the stack; ret wins over branch+call.
    do_reset();
    call(16'h50, 16'h30); call(16'h50, 16'h31);
    drive(0,1,1,16'h100,0,0,0,0,0);
    expect_now("flush_over_stall", 16'h100, 1'b1, 1'b0);
    call(16'h200, 16'h77);
    drive(0,0,0,0,1,16'h300,1,16'h99,1);
    expect_now("ret_over_branch", 16'h77, 1'b1, 1'b0);

    // Wrap from all-ones, then reset overriding a pending return.
    drive(0,0,0,0,1,16'hFFFF,0,0,0);
    free();
    expect_now("pc_wrap", 16'h0000, 1'b1, 1'b0);
    ret();
    expect_now("underflow_from_empty", 16'h0001, 1'b1, 1'b1);
    drive(1,1,0,0,0,0,0,0,1);
    expect_now("reset_over_ret", RV, 1'b1, 1'b0);
    free(); ret(); call(16'h10, 16'h11);
    drive(0,0,1,16'h40,0,0,0,0,0);
    expect_now("flush_keeps_err", 16'h40, 1'b1, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bit r, s, f, b, c, rt;
      logic [AW-1:0] fa, ba, ra;
      r  = ($urandom_range(63) == 0);
      f  = ($urandom_range(15) == 0);
      s  = ($urandom_range(3) == 0);
      rt = ($urandom_range(4) == 0);
      b  = ($urandom_range(2) == 0);
      c  = ($urandom_range(1) == 0);
      fa = 16'($urandom);
      ba = ($urandom_range(7) == 0) ? 16'hFFFE : 16'($urandom);
      ra = 16'($urandom);
      drive(r, s, f, fa, b, ba, c, ra, rt);
    end
    free();

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #3;
    if (exp_q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d records left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
